ps2_key_tracker: RTL and testbench

//  Consumes PS/2 scan-code bytes from the ps2_keyboard receiver FIFO and decodes them.

---
 rtl/ps2_key_tracker.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code tracker: pops bytes from the receiver FIFO, decodes make/break/E0 sequences,
// filters typematic repeats, counts presses and keeps a circular history of pressed keys.
module ps2_key_tracker #(
  parameter int CNT_W         = 8,
  parameter int DEPTH         = 8,
  parameter int COUNT_REPEATS = 0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic             rx_nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_repeat,
  output logic             key_held,
  output logic [CNT_W-1:0] press_count,
  input  logic             hist_rd,
  output logic [8:0]       hist_code,
  output logic             hist_empty,
  output logic             hist_full,
  output logic             hist_ovf,
  output logic             err_seq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_E0   = 2'd1;
  localparam logic [1:0] S_F0   = 2'd2;
  localparam logic [1:0] S_E0F0 = 2'd3;

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_AA = 8'hAA;

  logic [1:0]       state_q, state_d;
  logic             rx_nextdata_n_q, rx_nextdata_n_d;
  logic             key_valid_q, key_valid_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic             key_break_q, key_break_d;
  logic             key_repeat_q, key_repeat_d;
  logic             key_held_q, key_held_d;
  logic [8:0]       held_q, held_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic             err_seq_q, err_seq_d;
  logic [8:0]       mem_q [DEPTH];
  logic [8:0]       mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             hist_ovf_q, hist_ovf_d;

  logic consume, ev, ev_ext, ev_brk, err, match, rep, push, pop, full;

  // Byte decoder: the FSM only remembers which prefixes have been seen.
  always_comb begin
    consume = rx_ready & rx_nextdata_n_q;
    ev      = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    err     = 1'b0;
    state_d = state_q;
    if (consume) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == B_E0)      state_d = S_E0;
          else if (rx_data == B_F0) state_d = S_F0;
          else if (rx_data != B_FA && rx_data != B_AA) ev = 1'b1;
        end
        S_E0: begin
          if (rx_data == B_F0)      state_d = S_E0F0;
          else if (rx_data == B_E0) err = 1'b1;
          else begin
            ev      = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          if (rx_data == B_E0 || rx_data == B_F0) err = 1'b1;
          else begin
            ev     = 1'b1;
            ev_brk = 1'b1;
            ev_ext = (state_q == S_E0F0);
          end
        end
      endcase
    end
  end

  // Key event handling: a single tracked key distinguishes new presses from repeats.
  always_comb begin
    rx_nextdata_n_d = ~consume;
    match           = key_held_q && (held_q == {ev_ext, rx_data});
    rep             = ev & ~ev_brk & match;
    push            = ev & ~ev_brk & (~match | (COUNT_REPEATS != 0));
    key_valid_d     = ev;
    err_seq_d       = err;
    key_code_d      = key_code_q;
    key_ext_d       = key_ext_q;
    key_break_d     = key_break_q;
    key_repeat_d    = key_repeat_q;
    key_held_d      = key_held_q;
    held_d          = held_q;
    press_count_d   = push ? press_count_q + CNT_W'(1) : press_count_q;
    if (ev) begin
      key_code_d   = rx_data;
      key_ext_d    = ev_ext;
      key_break_d  = ev_brk;
      key_repeat_d = rep;
      if (!ev_brk && !match) begin
        held_d     = {ev_ext, rx_data};
        key_held_d = 1'b1;
      end else if (ev_brk && match) begin
        key_held_d = 1'b0;
      end
    end
  end

  // History ring: a push into a full ring without a pop evicts the oldest entry.
  always_comb begin
    full       = (cnt_q == FULL_CNT);
    pop        = hist_rd && (cnt_q != '0);
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    hist_ovf_d = hist_ovf_q;
    if (push) begin
      mem_d[wr_q] = {ev_ext, rx_data};
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    if (push && !pop) begin
      if (full) begin
        rd_d       = rd_q + AW'(1);
        hist_ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + (AW+1)'(1);
      end
    end else if (pop && !push) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q         <= S_IDLE;
      rx_nextdata_n_q <= 1'b1;
      key_valid_q     <= 1'b0;
      key_code_q      <= '0;
      key_ext_q       <= 1'b0;
      key_break_q     <= 1'b0;
      key_repeat_q    <= 1'b0;
      key_held_q      <= 1'b0;
      held_q          <= '0;
      press_count_q   <= '0;
      err_seq_q       <= 1'b0;
      wr_q            <= '0;
      rd_q            <= '0;
      cnt_q           <= '0;
      hist_ovf_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      rx_nextdata_n_q <= rx_nextdata_n_d;
      key_valid_q     <= key_valid_d;
      key_code_q      <= key_code_d;
      key_ext_q       <= key_ext_d;
      key_break_q     <= key_break_d;
      key_repeat_q    <= key_repeat_d;
      key_held_q      <= key_held_d;
      held_q          <= held_d;
      press_count_q   <= press_count_d;
      err_seq_q       <= err_seq_d;
      wr_q            <= wr_d;
      rd_q            <= rd_d;
      cnt_q           <= cnt_d;
      hist_ovf_q      <= hist_ovf_d;
      mem_q           <= mem_d;
    end
  end

  assign rx_nextdata_n = rx_nextdata_n_q;
  assign key_valid     = key_valid_q;
  assign key_code      = key_code_q;
  assign key_ext       = key_ext_q;
  assign key_break     = key_break_q;
  assign key_repeat    = key_repeat_q;
  assign key_held      = key_held_q;
  assign press_count   = press_count_q;
  assign err_seq       = err_seq_q;
  assign hist_empty    = (cnt_q == '0);
  assign hist_full     = full;
  assign hist_ovf      = hist_ovf_q;
  assign hist_code     = (cnt_q == '0) ? 9'h000 : mem_q[rd_q];
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed vector table, corner sequences, then random bytes vs a prefix-flag model.
module tb_ps2_key_tracker;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       hist_rd = 1'b0;

  logic       nd0, kv0, ke0, kb0, kr0, kh0, he0, hf0, ho0, es0;
  logic [7:0] kc0, pc0;
  logic [8:0] hc0;
  logic       nd1, kv1, ke1, kb1, kr1, kh1, he1, hf1, ho1, es1;
  logic [7:0] kc1, pc1;
  logic [8:0] hc1;

  always #5 clk = ~clk;

  ps2_key_tracker #(.CNT_W(8), .DEPTH(DEPTH), .COUNT_REPEATS(0)) dut0 (
    .clk(clk), .clrn(clrn), .rx_data(rx_data), .rx_ready(rx_ready), .rx_nextdata_n(nd0),
    .key_valid(kv0), .key_code(kc0), .key_ext(ke0), .key_break(kb0), .key_repeat(kr0),
    .key_held(kh0), .press_count(pc0), .hist_rd(hist_rd), .hist_code(hc0),
    .hist_empty(he0), .hist_full(hf0), .hist_ovf(ho0), .err_seq(es0));

  ps2_key_tracker #(.CNT_W(8), .DEPTH(DEPTH), .COUNT_REPEATS(1)) dut1 (
    .clk(clk), .clrn(clrn), .rx_data(rx_data), .rx_ready(rx_ready), .rx_nextdata_n(nd1),
    .key_valid(kv1), .key_code(kc1), .key_ext(ke1), .key_break(kb1), .key_repeat(kr1),
    .key_held(kh1), .press_count(pc1), .hist_rd(1'b0), .hist_code(hc1),
    .hist_empty(he1), .hist_full(hf1), .hist_ovf(ho1), .err_seq(es1));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] b;
    logic       v;
    logic [7:0] code;
    logic       ext, brk, rep, err, held;
    logic [7:0] cnt0, cnt1;
    logic [8:0] hc;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [7:0] b, logic v, logic [7:0] code, logic ext,
                              logic brk, logic rep, logic err, logic held, logic [7:0] cnt0,
                              logic [7:0] cnt1, logic [8:0] hc);
    vec_t t;
    t.rst = rst; t.b = b; t.v = v; t.code = code; t.ext = ext; t.brk = brk; t.rep = rep;
    t.err = err; t.held = held; t.cnt0 = cnt0; t.cnt1 = cnt1; t.hc = hc;
    return t;
  endfunction

  // Behavioural model: prefix flags, one tracked key, history as a queue.
  bit         m_e0, m_f0, m_hv, m_valid, m_err, m_ext, m_brk, m_rep, m_ovf;
  logic [8:0] m_held;
  logic [7:0] m_code;
  int         m_cnt0, m_cnt1;
  logic [8:0] m_q[$];

  task automatic model_reset();
    m_e0 = 0; m_f0 = 0; m_hv = 0; m_valid = 0; m_err = 0; m_ext = 0; m_brk = 0; m_rep = 0;
    m_ovf = 0; m_held = '0; m_code = '0; m_cnt0 = 0; m_cnt1 = 0; m_q.delete();
  endtask

  task automatic model_hist(input bit rd, input bit push, input logic [8:0] val);
    if (rd && m_q.size() > 0) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() == DEPTH) begin
        void'(m_q.pop_front());
        m_ovf = 1;
      end
      m_q.push_back(val);
    end
  endtask

  task automatic model_step(input logic [7:0] b, input bit rd);
    bit ev, ext, brk;
    ev = 0; ext = 0; brk = 0;
    m_valid = 0; m_err = 0;
    if (m_f0) begin
      if (b == 8'hE0 || b == 8'hF0) m_err = 1;
      else begin ev = 1; brk = 1; ext = m_e0; end
      m_e0 = 0; m_f0 = 0;
    end else if (m_e0) begin
      if (b == 8'hF0) m_f0 = 1;
      else if (b == 8'hE0) m_err = 1;
      else begin ev = 1; ext = 1; m_e0 = 0; end
    end else begin
      if (b == 8'hE0) m_e0 = 1;
      else if (b == 8'hF0) m_f0 = 1;
      else if (b != 8'hFA && b != 8'hAA) ev = 1;
    end
    if (ev) begin
      bit same;
      same = m_hv && (m_held == {ext, b});
      m_valid = 1; m_code = b; m_ext = ext; m_brk = brk; m_rep = !brk && same;
      if (!brk && !same) begin m_held = {ext, b}; m_hv = 1; end
      if (brk && same) m_hv = 0;
      if (!brk) begin
        m_cnt1 = (m_cnt1 + 1) % 256;
        if (!same) m_cnt0 = (m_cnt0 + 1) % 256;
      end
      model_hist(rd, !brk && !same, {ext, b});
    end else begin
      model_hist(rd, 0, 9'h0);
    end
  endtask

  task automatic model_cmp(input logic exp_nd);
    chk("rnd.nextdata_n", nd0, exp_nd);
    chk("rnd.key_valid", kv0, m_valid);
    chk("rnd.key_code", kc0, m_code);
    chk("rnd.key_ext", ke0, m_ext);
    chk("rnd.key_break", kb0, m_brk);
    chk("rnd.key_repeat", kr0, m_rep);
    chk("rnd.err_seq", es0, m_err);
    chk("rnd.key_held", kh0, m_hv);
    chk("rnd.press_count0", pc0, m_cnt0);
    chk("rnd.press_count1", pc1, m_cnt1);
    chk("rnd.hist_empty", he0, m_q.size() == 0);
    chk("rnd.hist_full", hf0, m_q.size() == DEPTH);
    chk("rnd.hist_ovf", ho0, m_ovf);
    chk("rnd.hist_code", hc0, (m_q.size() == 0) ? 9'h0 : m_q[0]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 0; rx_ready = 0; hist_rd = 0;
    @(negedge clk);
    chk("rst.nextdata_n", nd0, 1); chk("rst.key_valid", kv0, 0); chk("rst.key_code", kc0, 0);
    chk("rst.key_held", kh0, 0); chk("rst.press_count", pc0, 0); chk("rst.hist_empty", he0, 1);
    chk("rst.hist_full", hf0, 0); chk("rst.hist_ovf", ho0, 0); chk("rst.hist_code", hc0, 0);
    chk("rst.err_seq", es0, 0);
    clrn = 1;
    model_reset();
  endtask

  // One byte through the handshake; outputs are sampled on the negedge after the consume edge.
  task automatic drive_byte(input logic [7:0] b, input bit rd);
    @(negedge clk);
    rx_data = b; rx_ready = 1; hist_rd = rd;
    @(negedge clk);
    rx_ready = 0; hist_rd = 0;
  endtask

  task automatic pop_only();
    @(negedge clk);
    hist_rd = 1;
    @(negedge clk);
    hist_rd = 0;
  endtask

  vec_t tbl[17];
  logic [7:0] pool[8];

  initial begin
    tbl[0]  = mk(1, 8'h1C, 1, 8'h1C, 0, 0, 0, 0, 1, 1, 1, 9'h01C);
    tbl[1]  = mk(0, 8'hF0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 9'h01C);
    tbl[2]  = mk(0, 8'h1C, 1, 8'h1C, 0, 1, 0, 0, 0, 1, 1, 9'h01C);
    tbl[3]  = mk(1, 8'hE0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 9'h000);
    tbl[4]  = mk(0, 8'h75, 1, 8'h75, 1, 0, 0, 0, 1, 1, 1, 9'h175);
    tbl[5]  = mk(0, 8'hE0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 9'h175);
    tbl[6]  = mk(0, 8'hF0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 9'h175);
    tbl[7]  = mk(0, 8'h75, 1, 8'h75, 1, 1, 0, 0, 0, 1, 1, 9'h175);
    tbl[8]  = mk(1, 8'h1C, 1, 8'h1C, 0, 0, 0, 0, 1, 1, 1, 9'h01C);
    tbl[9]  = mk(0, 8'h1C, 1, 8'h1C, 0, 0, 1, 0, 1, 1, 2, 9'h01C);
    tbl[10] = mk(0, 8'h1C, 1, 8'h1C, 0, 0, 1, 0, 1, 1, 3, 9'h01C);
    tbl[11] = mk(0, 8'h1C, 1, 8'h1C, 0, 0, 1, 0, 1, 1, 4, 9'h01C);
    tbl[12] = mk(0, 8'hF0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 4, 9'h01C);
    tbl[13] = mk(0, 8'h1C, 1, 8'h1C, 0, 1, 0, 0, 0, 1, 4, 9'h01C);
    tbl[14] = mk(1, 8'hF0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 9'h000);
    tbl[15] = mk(0, 8'hE0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 9'h000);
    tbl[16] = mk(0, 8'h1C, 1, 8'h1C, 0, 0, 0, 0, 1, 1, 1, 9'h01C);

    repeat (2) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].rst) do_reset();
      drive_byte(tbl[i].b, 0);
      chk("tbl.key_valid", kv0, tbl[i].v);
      chk("tbl.err_seq", es0, tbl[i].err);
      chk("tbl.nextdata_n", nd0, 0);
      if (tbl[i].v) begin
        chk("tbl.key_code", kc0, tbl[i].code);
        chk("tbl.key_ext", ke0, tbl[i].ext);
        chk("tbl.key_break", kb0, tbl[i].brk);
        chk("tbl.key_repeat", kr0, tbl[i].rep);
      end
      chk("tbl.key_held", kh0, tbl[i].held);
      chk("tbl.press_count0", pc0, tbl[i].cnt0);
      chk("tbl.press_count1", pc1, tbl[i].cnt1);
      chk("tbl.hist_code", hc0, tbl[i].hc);
    end

    // Overflow: DEPTH+1 distinct presses without reads.
    do_reset();
    for (int i = 0; i <= DEPTH; i++) drive_byte(8'h15 + 8'(i), 0);
    chk("ovf.hist_full", hf0, 1);
    chk("ovf.hist_ovf", ho0, 1);
    chk("ovf.hist_code", hc0, 9'h016);
    chk("ovf.press_count", pc0, DEPTH + 1);
    pop_only();
    chk("ovf.pop_code", hc0, 9'h017);
    chk("ovf.pop_full", hf0, 0);
    chk("ovf.ovf_sticky", ho0, 1);

    // Pop on empty is ignored.
    do_reset();
    pop_only();
    chk("popempty.hist_empty", he0, 1);
    chk("popempty.hist_code", hc0, 0);

    // Held rx_ready: consume at most every other cycle.
    do_reset();
    @(negedge clk);
    rx_data = 8'h1C; rx_ready = 1;
    for (int i = 0; i < 6; i++) begin
      chk("rate.nextdata_n", nd0, (i % 2 == 0) ? 1 : 0);
      @(negedge clk);
    end
    rx_ready = 0;
    chk("rate.press_count", pc0, 1);
    chk("rate.repeat", kr0, 1);

    // Reset right after an E0 prefix drops the prefix and releases the pop strobe.
    do_reset();
    @(negedge clk);
    rx_data = 8'hE0; rx_ready = 1;
    @(negedge clk);
    rx_ready = 0; clrn = 0;
    chk("midrst.nextdata_low", nd0, 0);
    @(negedge clk);
    chk("midrst.nextdata_high", nd0, 1);
    clrn = 1;
    drive_byte(8'h1C, 0);
    chk("midrst.key_valid", kv0, 1);
    chk("midrst.key_ext", ke0, 0);
    chk("midrst.key_code", kc0, 8'h1C);

    // Random byte stream against the model.
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'hFA; pool[3] = 8'hAA;
    pool[4] = 8'h1C; pool[5] = 8'h75; pool[6] = 8'h15; pool[7] = 8'h16;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        pop_only();
        model_hist(1, 0, 9'h0);
        m_valid = 0; m_err = 0;
        model_cmp(1);
      end else begin
        logic [7:0] b;
        bit rd;
        b = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : pool[$urandom_range(4, 7)];
        rd = ($urandom_range(0, 3) == 0);
        drive_byte(b, rd);
        model_step(b, rd);
        model_cmp(0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
